// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store queue: opcodes, sizes,
// queue entry layout and lane/strobe helpers.
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2a;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SWR = 6'h2e;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [5:0]  op;
        logic [1:0]  a;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        is_load;
        logic        killed;
    } lsu_entry_t;

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU,
            OP_LW, OP_LL, OP_LWL, OP_LWR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW,
            OP_SC, OP_SWL, OP_SWR: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load_op(op) | is_store_op(op);
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] a);
        case (op)
            OP_LW, OP_LL, OP_SW, OP_SC: return a != 2'b00;
            OP_LH, OP_LHU, OP_SH:       return a[0];
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [5:0] op,
                                              input logic [1:0] a);
        logic [3:0] s;
        case (op)
            OP_SB:   s = 4'b0001 << a;
            OP_SH:   s = a[1] ? 4'b1100 : 4'b0011;
            OP_SWL:  s = ~(4'b1110 << a);
            OP_SWR:  s = 4'b1111 << a;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0]  op,
                                               input logic [1:0]  a,
                                               input logic [31:0] src);
        case (op)
            OP_SB:   return {4{src[7:0]}};
            OP_SH:   return {2{src[15:0]}};
            OP_SWL:  return src >> {~a, 3'b000};
            OP_SWR:  return src << {a, 3'b000};
            default: return src;
        endcase
    endfunction

    // Bytes of the old rt that survive an unaligned load merge.
    function automatic logic [31:0] lwl_keep(input logic [1:0] a);
        return ~(32'hffff_ffff << {~a, 3'b000});
    endfunction

    function automatic logic [31:0] lwr_keep(input logic [1:0] a);
        return ~(32'hffff_ffff >> {a, 3'b000});
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load return formatting: lane select, sign/zero extension
// and LWL/LWR merge with the previous rt value.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] rt_i,
    output logic [31:0] data_o
);

    logic [31:0] shr;
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign shr    = rdata_i >> {a_i, 3'b000};
    assign byte_l = shr[7:0];
    assign half_l = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{24{byte_l[7]}}, byte_l};
            OP_LBU:  data_o = {24'h0, byte_l};
            OP_LH:   data_o = {{16{half_l[15]}}, half_l};
            OP_LHU:  data_o = {16'h0, half_l};
            OP_LWL:  data_o = (rdata_i << {~a_i, 3'b000})
                            | (rt_i & lwl_keep(a_i));
            OP_LWR:  data_o = shr | (rt_i & lwr_keep(a_i));
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_queue.sv
// Load/store unit: slot select, alignment check, store formatting
// and an in-order queue of outstanding bus transactions.
module lsu_queue
    import lsu_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SLOTS-1:0]    slot_valid,
    input  logic [6*NUM_SLOTS-1:0]  slot_op,
    input  logic [ADDR_W*NUM_SLOTS-1:0] slot_addr,
    input  logic [32*NUM_SLOTS-1:0] slot_wdata,
    input  logic [32*NUM_SLOTS-1:0] slot_rt,
    input  logic [5*NUM_SLOTS-1:0]  slot_dest,
    input  logic                    flush,
    output logic [NUM_SLOTS-1:0]    adel,
    output logic [NUM_SLOTS-1:0]    ades,
    output logic                    lsu_stall,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [ADDR_W-1:0]       data_addr,
    output logic [3:0]              data_wstrb,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [31:0]             data_rdata,
    output logic                    ld_valid,
    output logic [4:0]              ld_dest,
    output logic [31:0]             ld_data,
    output logic                    busy,
    output logic                    proto_err
);

    localparam int PW = $clog2(DEPTH);

    logic              sel_v;
    logic [5:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wd;
    logic [31:0]       sel_rt;
    logic [4:0]        sel_dest;
    logic              sel_go;
    logic              sel_st;

    always_comb begin
        sel_v    = 1'b0;
        sel_op   = '0;
        sel_addr = '0;
        sel_wd   = '0;
        sel_rt   = '0;
        sel_dest = '0;
        // Walk downward so the lowest-index candidate wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_valid[i] && is_mem_op(slot_op[i*6 +: 6])) begin
                sel_v    = 1'b1;
                sel_op   = slot_op[i*6 +: 6];
                sel_addr = slot_addr[i*ADDR_W +: ADDR_W];
                sel_wd   = slot_wdata[i*32 +: 32];
                sel_rt   = slot_rt[i*32 +: 32];
                sel_dest = slot_dest[i*5 +: 5];
            end
        end
    end

    always_comb begin
        adel = '0;
        ades = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid[i]
                && misaligned(slot_op[i*6 +: 6],
                              slot_addr[i*ADDR_W +: 2])) begin
                adel[i] = is_load_op(slot_op[i*6 +: 6]);
                ades[i] = is_store_op(slot_op[i*6 +: 6]);
            end
        end
    end

    lsu_entry_t      q_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            proto_err_q, proto_err_d;
    logic            ld_valid_q, ld_valid_d;
    logic [4:0]      ld_dest_q;
    logic [31:0]     ld_data_q;
    logic [31:0]     align_data;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    lsu_entry_t      head;
    lsu_entry_t      push_e;

    assign full   = cnt_q == (PW+1)'(DEPTH);
    assign empty  = cnt_q == '0;
    assign sel_go = sel_v & ~misaligned(sel_op, sel_addr[1:0]);
    assign sel_st = is_store_op(sel_op);

    assign data_req  = sel_go & ~flush & ~full & rst;
    assign push      = data_req & data_addr_ok;
    assign pop       = data_data_ok & ~empty;
    assign lsu_stall = sel_go & ~push;

    assign data_wr    = data_req & sel_st;
    assign data_size  = data_req ? op_size(sel_op) : 2'd0;
    assign data_addr  = data_req ? sel_addr : '0;
    assign data_wstrb = data_wr ? store_strb(sel_op, sel_addr[1:0]) : 4'h0;
    assign data_wdata = data_wr
                      ? store_data(sel_op, sel_addr[1:0], sel_wd)
                      : 32'h0;

    assign head = q_q[rd_ptr_q];

    always_comb begin
        push_e         = '0;
        push_e.op      = sel_op;
        push_e.a       = sel_addr[1:0];
        push_e.rt      = sel_rt;
        push_e.dest    = sel_dest;
        push_e.is_load = is_load_op(sel_op);
        push_e.killed  = flush;
    end

    lsu_load_align u_align (
        .op_i    (head.op),
        .a_i     (head.a),
        .rdata_i (data_rdata),
        .rt_i    (head.rt),
        .data_o  (align_data)
    );

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d       = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        proto_err_d = proto_err_q | (data_data_ok & empty);
        ld_valid_d  = pop & head.is_load & ~head.killed & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_dest_q   <= '0;
            ld_data_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            ld_valid_q  <= ld_valid_d;
            if (ld_valid_d) begin
                ld_dest_q <= head.dest;
                ld_data_q <= align_data;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    q_q[i].killed <= 1'b1;
                end
            end
            if (push) begin
                q_q[wr_ptr_q] <= push_e;
            end
        end
    end

    assign ld_valid  = ld_valid_q;
    assign ld_dest   = ld_dest_q;
    assign ld_data   = ld_data_q;
    assign busy      = ~empty;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_lsu_queue.sv
// Directed bench for lsu_queue: store formatting, alignment faults,
// load extension/merge, queue full, flush squash and protocol error.
module tb_lsu_queue;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  slot_valid;
    logic [11:0] slot_op;
    logic [63:0] slot_addr;
    logic [63:0] slot_wdata;
    logic [63:0] slot_rt;
    logic [9:0]  slot_dest;
    logic        flush;
    logic [1:0]  adel, ades;
    logic        lsu_stall;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        ld_valid;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic        busy, proto_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    lsu_queue #(.NUM_SLOTS(2), .DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .slot_valid(slot_valid), .slot_op(slot_op),
        .slot_addr(slot_addr), .slot_wdata(slot_wdata),
        .slot_rt(slot_rt), .slot_dest(slot_dest),
        .flush(flush), .adel(adel), .ades(ades),
        .lsu_stall(lsu_stall), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .busy(busy), .proto_err(proto_err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_slots();
        slot_valid = '0;
        slot_op    = '0;
        slot_addr  = '0;
        slot_wdata = '0;
        slot_rt    = '0;
        slot_dest  = '0;
    endtask

    task automatic set_slot(input int s, input logic [5:0] op,
                            input logic [31:0] addr,
                            input logic [31:0] wd,
                            input logic [31:0] rt,
                            input logic [4:0] dest);
        slot_valid[s]        = 1'b1;
        slot_op[s*6 +: 6]    = op;
        slot_addr[s*32 +: 32] = addr;
        slot_wdata[s*32 +: 32] = wd;
        slot_rt[s*32 +: 32]  = rt;
        slot_dest[s*5 +: 5]  = dest;
    endtask

    task automatic do_store(input string tag, input int s,
                            input logic [5:0] op,
                            input logic [31:0] addr,
                            input logic [31:0] wd,
                            input logic [1:0] esz,
                            input logic [3:0] estrb,
                            input logic [31:0] ewd);
        set_slot(s, op, addr, wd, 32'h0, 5'd0);
        data_addr_ok = 1'b1;
        #1;
        chk({tag, "_req"}, 32'(data_req), 32'd1);
        chk({tag, "_wr"}, 32'(data_wr), 32'd1);
        chk({tag, "_size"}, 32'(data_size), 32'(esz));
        chk({tag, "_addr"}, data_addr, addr);
        chk({tag, "_strb"}, 32'(data_wstrb), 32'(estrb));
        chk({tag, "_wdata"}, data_wdata, ewd);
        tick();
        clr_slots();
        data_addr_ok = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk({tag, "_nold"}, 32'(ld_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [5:0] op,
                           input logic [31:0] addr,
                           input logic [31:0] rt,
                           input logic [4:0] dest,
                           input logic [31:0] rdata,
                           input logic [31:0] exp);
        set_slot(0, op, addr, 32'h0, rt, dest);
        data_addr_ok = 1'b1;
        #1;
        chk({tag, "_req"}, 32'(data_req), 32'd1);
        tick();
        clr_slots();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();
        data_data_ok = 1'b0;
        chk({tag, "_vld"}, 32'(ld_valid), 32'd1);
        chk({tag, "_data"}, ld_data, exp);
        chk({tag, "_dest"}, 32'(ld_dest), 32'(dest));
        tick();
        chk({tag, "_pulse"}, 32'(ld_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = '0;
        clr_slots();
        tick();
        tick();
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_ldv", 32'(ld_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        rst = 1'b1;
        tick();

        do_store("sw", 1, OP_SW, 32'h1004, 32'ha1b2c3d4,
                 SZ_WORD, 4'b1111, 32'ha1b2c3d4);
        do_store("sb", 0, OP_SB, 32'h0003, 32'h1234565a,
                 SZ_BYTE, 4'b1000, 32'h5a5a5a5a);
        do_store("sh", 0, OP_SH, 32'h0006, 32'h0000beef,
                 SZ_HALF, 4'b1100, 32'hbeefbeef);
        do_store("swl", 0, OP_SWL, 32'h0021, 32'haabbccdd,
                 SZ_WORD, 4'b0011, 32'h0000aabb);
        do_store("swr", 0, OP_SWR, 32'h0022, 32'haabbccdd,
                 SZ_WORD, 4'b1100, 32'hccdd0000);

        set_slot(0, OP_LH, 32'h2003, 32'h0, 32'h0, 5'd3);
        set_slot(1, OP_SH, 32'h0005, 32'h0, 32'h0, 5'd0);
        data_addr_ok = 1'b1;
        #1;
        chk("mis_adel", 32'(adel), 32'b01);
        chk("mis_ades", 32'(ades), 32'b10);
        chk("mis_req", 32'(data_req), 32'd0);
        chk("mis_stall", 32'(lsu_stall), 32'd0);
        tick();
        chk("mis_busy", 32'(busy), 32'd0);
        clr_slots();

        set_slot(0, OP_LW, 32'h0040, 32'h0, 32'h0, 5'd2);
        set_slot(1, OP_SW, 32'h0080, 32'h1, 32'h0, 5'd0);
        data_addr_ok = 1'b0;
        #1;
        chk("pri_addr", data_addr, 32'h0040);
        chk("pri_wr", 32'(data_wr), 32'd0);
        chk("pri_stall", 32'(lsu_stall), 32'd1);
        tick();
        chk("pri_busy", 32'(busy), 32'd0);
        clr_slots();

        do_load("lb", OP_LB, 32'h11, 32'h0, 5'd4,
                32'h0080ff00, 32'hffffffff);
        do_load("lbu", OP_LBU, 32'h11, 32'h0, 5'd5,
                32'h0080ff00, 32'h000000ff);
        do_load("lh", OP_LH, 32'h12, 32'h0, 5'd6,
                32'h80010000, 32'hffff8001);
        do_load("lhu", OP_LHU, 32'h10, 32'h0, 5'd7,
                32'h1234f00d, 32'h0000f00d);
        do_load("lwl", OP_LWL, 32'h21, 32'haabbccdd, 5'd8,
                32'h11223344, 32'h3344ccdd);
        do_load("lwr", OP_LWR, 32'h21, 32'haabbccdd, 5'd9,
                32'h11223344, 32'haa112233);
        do_load("lw", OP_LW, 32'h30, 32'h0, 5'd10,
                32'hdeadbeef, 32'hdeadbeef);

        data_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_slot(0, OP_LW, 32'h100 + 32'(4*k), 32'h0, 32'h0,
                     5'(k + 1));
            #1;
            chk("full_fill", 32'(data_req), 32'd1);
            tick();
        end
        set_slot(0, OP_LW, 32'h110, 32'h0, 32'h0, 5'd5);
        #1;
        chk("full_stall", 32'(lsu_stall), 32'd1);
        chk("full_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1;
        data_rdata = 32'h11111111;
        #1;
        chk("full_poprq", 32'(data_req), 32'd0);
        tick();
        data_data_ok = 1'b0;
        chk("full_ld1", ld_data, 32'h11111111);
        chk("full_dst1", 32'(ld_dest), 32'd1);
        chk("full_req5", 32'(data_req), 32'd1);
        tick();
        clr_slots();
        data_addr_ok = 1'b0;
        for (int k = 1; k < 5; k++) begin
            data_data_ok = 1'b1;
            data_rdata = 32'h11111111 * 32'(k + 1);
            tick();
            chk("drain_vld", 32'(ld_valid), 32'd1);
            chk("drain_data", ld_data, 32'h11111111 * 32'(k + 1));
            chk("drain_dest", 32'(ld_dest), 32'(k + 1));
        end
        data_data_ok = 1'b0;
        tick();
        chk("drain_busy", 32'(busy), 32'd0);

        data_addr_ok = 1'b1;
        set_slot(0, OP_LW, 32'h200, 32'h0, 32'h0, 5'd12);
        tick();
        set_slot(0, OP_LW, 32'h204, 32'h0, 32'h0, 5'd13);
        tick();
        clr_slots();
        data_addr_ok = 1'b0;
        chk("fl_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h12345678;
        tick();
        chk("fl_sq1", 32'(ld_valid), 32'd0);
        tick();
        chk("fl_sq2", 32'(ld_valid), 32'd0);
        data_data_ok = 1'b0;
        chk("fl_idle", 32'(busy), 32'd0);
        chk("fl_perr0", 32'(proto_err), 32'd0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("perr_set", 32'(proto_err), 32'd1);
        tick();
        chk("perr_stk", 32'(proto_err), 32'd1);
        rst = 1'b0;
        tick();
        chk("perr_rst", 32'(proto_err), 32'd0);
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_queue.md
# lsu_queue

Parametrised load/store unit sitting between the E and M stages of the dual-issue pipeline and the SRAM-like data bus. Selects one memory op per cycle from NUM_SLOTS issue slots and checks alignment. Generates byte strobes and lane-replicated write data. Tracks up to DEPTH outstanding bus transactions in an in-order queue and returns aligned, sign/zero-extended (or LWL/LWR-merged) load results with flush-based squash.

## Interface
- NUM_SLOTS, 2, issue slots presented per cycle; lower index has priority
- DEPTH, 4, max outstanding bus transactions; power of two, ≥2
- ADDR_W, 32, address width
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst==0 resets on the rising edge of clk)
- slot_valid  in  NUM_SLOTS  slot carries a memory op
- slot_op  in  6*NUM_SLOTS  opcode [31:26] per slot
- slot_addr  in  ADDR_W*NUM_SLOTS  effective address
- slot_wdata  in  32*NUM_SLOTS  store source
- slot_rt  in  32*NUM_SLOTS  old rt value (LWL/LWR merge)
- slot_dest  in  5*NUM_SLOTS  load destination register
- flush  in  1  pipeline flush
- adel, ades  out  NUM_SLOTS each  per-slot load/store address error, combinational
- lsu_stall  out  1  selected op not accepted this cycle
- data_req, data_wr  out  1 each  bus request / write
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  ADDR_W; data_wstrb  out  4; data_wdata  out  32
- data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32
- ld_valid  out  1; ld_dest  out  5; ld_data  out  32  registered load result
- busy  out  1  queue non-empty
- proto_err  out  1  sticky: data_ok received with empty queue

## Operation
- Select: lowest-index slot with slot_valid and a memory opcode (LB, LBU, LH, LHU, LW, LL, LWL, LWR, SB, SH, SW, SC, SWL, SWR).
- Alignment: LW/LL/SW/SC need addr[1:0]==0; LH/LHU/SH need addr[0]==0; others never fault. Faulting slot raises adel/ades and is never issued.
- Store strobes: SW/SC 1111; SH 0011/1100; SB one-hot of addr[1:0]; SWL ~(1110<<a); SWR 1111<<a. Write data: byte/half replicated across lanes; SWL src>>(8*(3-a)); SWR src<<(8*a).
- Issue: data_req = selected & no fault & !flush & count<DEPTH. Handshake on data_req&data_addr_ok pushes {op, addr[1:0], rt, dest, is_load, killed=0}.
- lsu_stall = selected & no fault & !(data_req & data_addr_ok).
- Full: push blocked even if a pop occurs the same cycle.
- Return: data_data_ok pops head. Non-killed load → next cycle ld_valid=1 with aligned data: LB/LBU, LH/LHU sign/zero-extend the addressed lane; LW/LL pass; LWL (rdata<<8*(3-a))|(rt & mask); LWR (rdata>>8*a)|(rt & ~mask). Stores and killed entries pop silently.
- Flush: sets killed on every queued entry, including one pushed that cycle. Bus transactions still complete and are drained. Pipeline contract: outstanding loads at flush are younger than the flushing instruction.
- data_data_ok with empty queue: ignored, proto_err set until reset.

## Timing
- Reset: all outputs 0, queue empty, pointers 0, proto_err 0.
- Request is combinational from slot inputs; the push is registered.
- A response may arrive the cycle after the handshake at earliest. ld_valid appears 1 cycle after data_ok and lasts one cycle.
- Same-cycle push and pop on a non-full queue: count unchanged, both take effect.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset mid-transaction discards the queue. The bus is reset by the same rst.

## Structure
- lsu_pkg: opcode localparams, size encoding, queue-entry struct, lane-mask helper functions.
- Sub-module lsu_load_align: combinational rdata/rt/op/a → ld_data.
- Queue, selector, and store-format logic live in lsu_queue.

## Test plan
- Slot1 SW addr 0x1004 data 0xA1B2C3D4, slot0 idle, addr_ok=1 → data_wstrb 1111, data_wdata 0xA1B2C3D4, size 2; no ld_valid.
- LH addr 0x2003 → adel[slot]=1, data_req=0, queue unchanged.
- LB addr 0x11 (a=1), rdata 0x0080FF00 → ld_data 0xFFFFFFFF; LBU same → 0x000000FF.
- LWL a=1, rdata 0x11223344, rt 0xAABBCCDD → ld_data 0x3344CCDD; LWR a=1 → 0xAA112233.
- DEPTH=4: four loads accepted with data_ok withheld; fifth sees lsu_stall=1, data_req=0. One data_ok frees one slot and the fifth issues the next cycle.
- Two loads outstanding, flush pulsed, then two data_ok → no ld_valid, busy falls to 0. A further data_ok with empty queue → proto_err=1.
